// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared definitions for the register writeback queue.
//   DEF_DATA_W / DEF_ADDR_W : default register data and address widths
//   REG_ZERO                : hardwired-zero register; writes to it are dropped
//   wb_entry_t              : one queued write request {addr, data}
package reg_wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int REG_ZERO   = 0;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_entry    : enqueue request (ignored when full)
//   pop, head           : dequeue request (ignored when empty), current head entry
//   count, full, empty  : occupancy
//   entry_valid         : per-slot flag, slot currently holds a queued entry
//   entry_addr          : per-slot stored register address
module wb_fifo
  import reg_wb_pkg::*;
#(
  parameter type entry_t = wb_entry_t,
  parameter int  ADDR_W  = DEF_ADDR_W,
  parameter int  DEPTH   = 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  entry_t            push_entry,
  input  logic              pop,
  output entry_t            head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              entry_valid [DEPTH],
  output logic [ADDR_W-1:0] entry_addr  [DEPTH]
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; the count
  // alone tells full from empty when the pointers coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale slots are masked by entry_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign entry_valid[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count;
    assign entry_addr[i]  = mem[i].addr;
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: buffers register-file writes and issues one per cycle.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   wb_valid/wb_ready          : request handshake
//   wb_addr, wb_data           : destination register and value
//   drain_en                   : register-file write port free this cycle
//   reg_write, wr_addr, wr_data: registered register-file write port
//   rd_addr1/2, hazard1/2      : read addresses and pending-write hazard flags
//   count                      : entries queued (output stage excluded)
module reg_writeback_queue
  import reg_wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     drain_en,
  output logic                     reg_write,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic [$clog2(DEPTH):0]   count
);

  // Same layout as wb_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            push_entry;
  entry_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              enq;
  logic              do_pop;
  logic              entry_valid [DEPTH];
  logic [ADDR_W-1:0] entry_addr  [DEPTH];

  assign wb_ready   = !fifo_full;
  // Writes to the zero register complete the handshake but are dropped.
  assign enq        = wb_valid && wb_ready && (wb_addr != ADDR_W'(REG_ZERO));
  assign do_pop     = drain_en && !fifo_empty;
  assign push_entry = '{addr: wb_addr, data: wb_data};

  wb_fifo #(
    .entry_t (entry_t),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (enq),
    .push_entry  (push_entry),
    .pop         (do_pop),
    .head        (head),
    .count       (count),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // Output stage: a pop loads the head for exactly one cycle; otherwise
  // the address/data hold and only the enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else if (do_pop) begin
      reg_write <= 1'b1;
      wr_addr   <= head.addr;
      wr_data   <= head.data;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // A write still counts as pending while it sits in the output stage,
  // since the register file has not absorbed it until that cycle ends.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    if (rd_addr1 != ADDR_W'(REG_ZERO)) begin
      if (reg_write && (wr_addr == rd_addr1)) hazard1 = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_valid[i] && (entry_addr[i] == rd_addr1)) hazard1 = 1'b1;
      end
    end
    if (rd_addr2 != ADDR_W'(REG_ZERO)) begin
      if (reg_write && (wr_addr == rd_addr2)) hazard2 = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_valid[i] && (entry_addr[i] == rd_addr2)) hazard2 = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: self-checking bench for reg_writeback_queue with a
// queue-based reference model of the writeback behaviour.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        drain_en;
  logic        reg_write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        hazard1;
  logic        hazard2;
  logic [2:0]  count;

  int checks = 0;
  int fails  = 0;

  reg_writeback_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .drain_en  (drain_en),
    .reg_write (reg_write),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending requests in a queue plus the last issued write.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q [$];
  logic        m_rw;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          m_sz;
  bit          m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_rw = 1'b0;
      m_wa = '0;
      m_wd = '0;
    end else begin
      m_sz  = m_q.size();
      m_acc = wb_valid && (m_sz < DEPTH);
      if (drain_en && m_sz > 0) begin
        m_rw = 1'b1;
        m_wa = m_q[0].addr;
        m_wd = m_q[0].data;
        void'(m_q.pop_front());
      end else begin
        m_rw = 1'b0;
      end
      if (m_acc && wb_addr != 5'd0) m_q.push_back('{wb_addr, wb_data});
    end
  end

  function automatic bit m_hazard(logic [4:0] rd);
    if (rd == 5'd0) return 1'b0;
    if (m_rw && m_wa == rd) return 1'b1;
    foreach (m_q[i]) if (m_q[i].addr == rd) return 1'b1;
    return 1'b0;
  endfunction

  // Observable state packed as {reg_write, wr_addr, wr_data, count, wb_ready, hazard1, hazard2}
  function automatic logic [43:0] model_vec();
    return {m_rw, m_wa, m_wd, 3'(m_q.size()), (m_q.size() < DEPTH),
            m_hazard(rd_addr1), m_hazard(rd_addr2)};
  endfunction

  logic [43:0] act_vec;
  assign act_vec = {reg_write, wr_addr, wr_data, count, wb_ready, hazard1, hazard2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] a, input logic [31:0] d,
                               input logic dr);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
    drain_en = dr;
  endtask

  task automatic test_reset();
    #4;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({reg_write, wr_addr, wr_data, count, wb_ready, hazard1, hazard2} !==
        {1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("[TB] FAIL reset_state got %h expected %h", act_vec,
               {1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0});
    end
    repeat (3) @(posedge clk);
    #5;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    applyStimulus(1'b1, 5'd21, 32'd25, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    checks++;
    if ({reg_write, count} !== {1'b0, 3'd1}) begin
      fails++;
      $display("[TB] FAIL single_edgeN got rw=%b cnt=%0d expected rw=0 cnt=1", reg_write, count);
    end
    tick();
    checks++;
    if ({reg_write, wr_addr, wr_data, count} !== {1'b1, 5'd21, 32'd25, 3'd0}) begin
      fails++;
      $display("[TB] FAIL single_issue got rw=%b a=%0d d=%0d cnt=%0d expected 1/21/25/0",
               reg_write, wr_addr, wr_data, count);
    end
    tick();
    checks++;
    if (reg_write !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_pulse_end got rw=%b expected 0", reg_write);
    end
  endtask

  task automatic test_fill_stall();
    logic [4:0] issued [$];
    logic [4:0] exp_order [5];
    bit acc;
    exp_order = '{5'd21, 5'd22, 5'd23, 5'd24, 5'd25};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'(21 + i), 32'(25 + 10 * i), 1'b0);
      tick();
      checks++;
      if (act_vec !== model_vec()) begin
        fails++;
        $display("[TB] FAIL fill_push%0d got %h expected %h", i, act_vec, model_vec());
      end
    end
    applyStimulus(1'b1, 5'd25, 32'd65, 1'b0);
    rd_addr1 = 5'd22;
    rd_addr2 = 5'd9;
    tick();
    tick();
    checks++;
    if ({count, wb_ready, reg_write, hazard1, hazard2} !== {3'd4, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL full_stall got cnt=%0d rdy=%b rw=%b hz1=%b hz2=%b expected 4/0/0/1/0",
               count, wb_ready, reg_write, hazard1, hazard2);
    end
    drain_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc = wb_valid && (m_q.size() < DEPTH);
      tick();
      if (acc) wb_valid = 1'b0;
      if (reg_write) issued.push_back(wr_addr);
      checks++;
      if (act_vec !== model_vec()) begin
        fails++;
        $display("[TB] FAIL drain_cycle%0d got %h expected %h", i, act_vec, model_vec());
      end
    end
    checks++;
    if (issued.size() != 5) begin
      fails++;
      $display("[TB] FAIL drain_count got %0d writes expected 5", issued.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (issued[i] !== exp_order[i]) begin
          fails++;
          $display("[TB] FAIL drain_order%0d got %0d expected %0d", i, issued[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_zero_addr();
    applyStimulus(1'b1, 5'd0, 32'd99, 1'b1);
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd9;
    #1;
    checks++;
    if ({wb_ready, hazard1} !== {1'b1, 1'b0}) begin
      fails++;
      $display("[TB] FAIL zero_accept got rdy=%b hz1=%b expected 1/0", wb_ready, hazard1);
    end
    tick();
    wb_valid = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      fails++;
      $display("[TB] FAIL zero_count got %0d expected 0", count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (reg_write !== 1'b0) begin
        fails++;
        $display("[TB] FAIL zero_no_write%0d got rw=%b expected 0", i, reg_write);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    bit done = 1'b0;
    applyStimulus(1'b1, 5'd11, 32'd1, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd12, 32'd2, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd30, 32'd7, 1'b1);
    rd_addr1 = 5'd30;
    tick();
    wb_valid = 1'b0;
    checks++;
    if (count !== 3'd2) begin
      fails++;
      $display("[TB] FAIL simul_count got %0d expected 2", count);
    end
    for (int i = 0; i < 6 && !done; i++) begin
      checks++;
      if (act_vec !== model_vec()) begin
        fails++;
        $display("[TB] FAIL b2b_cycle%0d got %h expected %h", i, act_vec, model_vec());
      end
      if (seen) begin
        checks++;
        if ({reg_write, hazard1} !== 2'b00) begin
          fails++;
          $display("[TB] FAIL hazard_release got rw=%b hz1=%b expected 0/0", reg_write, hazard1);
        end
        done = 1'b1;
      end else if (reg_write && wr_addr == 5'd30) begin
        seen = 1'b1;
        checks++;
        if ({wr_data, hazard1} !== {32'd7, 1'b1}) begin
          fails++;
          $display("[TB] FAIL hazard_outstage got d=%0d hz1=%b expected 7/1", wr_data, hazard1);
        end
      end
      if (!done) tick();
    end
    if (!done) begin
      checks++;
      fails++;
      $display("[TB] FAIL b2b_timeout write to 30 not seen within bound");
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'(41 + i), 32'(100 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
    rd_addr1 = 5'd42;
    tick();
    drain_en = 1'b0;
    checks++;
    if ({reg_write, count, hazard1} !== {1'b1, 3'd3, 1'b1}) begin
      fails++;
      $display("[TB] FAIL pre_reset got rw=%b cnt=%0d hz1=%b expected 1/3/1",
               reg_write, count, hazard1);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({reg_write, count, hazard1, wb_ready} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("[TB] FAIL async_reset got rw=%b cnt=%0d hz1=%b rdy=%b expected 0/0/0/1",
               reg_write, count, hazard1, wb_ready);
    end
    repeat (2) @(posedge clk);
    #5;
    drain_en = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (reg_write !== 1'b0) begin
        fails++;
        $display("[TB] FAIL post_reset_idle%0d got rw=%b expected 0", i, reg_write);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom % 2), 5'($urandom_range(0, 7)), $urandom,
                    1'(($urandom % 4) != 0));
      rd_addr1 = 5'($urandom_range(0, 7));
      rd_addr2 = 5'($urandom_range(0, 7));
      #1;
      checks++;
      if (act_vec !== model_vec()) begin
        fails++;
        $display("[TB] FAIL random_comb%0d got %h expected %h", i, act_vec, model_vec());
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    $display("[TB] starting directed scenarios");
    test_reset();
    test_single();
    test_fill_stall();
    test_zero_addr();
    test_back_to_back();
    test_async_reset();
    $display("[TB] starting randomized scenario");
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
Buffers register-file write requests from the datapath's writeback side and issues them to the register file write port (write enable, write address, write data), one per cycle, in order. It is the writer-side counterpart to the register file's read ports. It flags read-after-write hazards for the two read addresses while a write is still pending. Writes to register 0 are absorbed and never issued.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (32 registers)
DEPTH, 4, queue entries; power of two, >= 2

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wb_valid  in  1  writeback request valid
wb_ready  out  1  queue can accept a request
wb_addr  in  ADDR_W  destination register of request
wb_data  in  DATA_W  value to write
drain_en  in  1  register-file write port available this cycle
reg_write  out  1  register-file write enable (registered)
wr_addr  out  ADDR_W  register-file write address (registered)
wr_data  out  DATA_W  register-file write data (registered)
rd_addr1  in  ADDR_W  register-file read address 1
rd_addr2  in  ADDR_W  register-file read address 2
hazard1  out  1  pending write targets rd_addr1
hazard2  out  1  pending write targets rd_addr2
count  out  $clog2(DEPTH)+1  entries currently queued (output stage excluded)

Behaviour:
- Interface decided: one clock; reset is asynchronous and active-low. The ports are clk and rst_n.
- Reset (asynchronous, immediate): queue empty, pointers 0, count=0, reg_write=0, wr_addr=0, wr_data=0. wb_ready=1 and hazard1/hazard2=0 follow combinationally from the empty state.
- wb_ready = (count < DEPTH), combinational. No pass-through when full.
- Accept: a handshake occurs at a rising edge when wb_valid && wb_ready. wb_addr/wb_data are sampled only on the handshake.
- wb_addr==0: the handshake completes but nothing is enqueued; count is unchanged.
- Pop: at a rising edge, if drain_en && count>0, the head entry moves to the output stage: reg_write<=1, wr_addr/wr_data<=head. Otherwise reg_write<=0 and wr_addr/wr_data hold their values.
- Latency: a request accepted at edge N into an empty queue with drain_en=1 is popped at edge N+1. reg_write is high for exactly the cycle between edges N+1 and N+2.
- Throughput: one issue per cycle. A simultaneous accept and pop in the same edge leaves count unchanged.
- Ordering: strict FIFO. Repeated writes to the same address are all issued, in acceptance order.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by count.
- hazardK (combinational) = (rd_addrK != 0) && (any queued entry has addr == rd_addrK || (reg_write && wr_addr == rd_addrK)).
- drain_en low with count>0: entries are retained indefinitely, hazards stay asserted.
- Reset mid-operation: all queued entries and any output-stage write are discarded. No write is issued after rst_n deasserts until a new request is accepted.

Decomposition:
- Package reg_wb_pkg:
  - DATA_W / ADDR_W defaults
  - constant REG_ZERO = 0
  - typedef wb_entry_t {addr, data}
- One sub-module, wb_fifo: parametric synchronous FIFO of wb_entry_t with push/pop/count. It also exposes per-entry valid and address vectors for the hazard comparators.
- Top level holds the zero-address filter, the registered output stage and the two comparator trees.

Test Plan:
- Reset: rst_n low 3 cycles mid-clock -> reg_write=0, wr_addr=0, wr_data=0, count=0, wb_ready=1, hazard1=hazard2=0.
- Single write addr 21 data 25, drain_en=1 accepted at edge N -> reg_write=1 only between edges N+1 and N+2, wr_addr=21, wr_data=25, count returns to 0.
- drain_en=0; push (21,25),(22,35),(23,45),(24,55) -> count=4, wb_ready=0, 5th request (25,65) stalls; rd_addr1=22 -> hazard1=1; rd_addr2=9 -> hazard2=0. Then drain_en=1 -> four consecutive reg_write pulses (21,22,23,24 in order), then (25,65) is accepted and issued.
- Push addr 0 data 99 -> handshake completes, count stays 0, reg_write never rises. rd_addr1=0 with a pending write to 0 attempted -> hazard1=0.
- count=2, drain_en=1, push (30,7) in the same cycle -> count stays 2. After (30,7) reaches the output stage, hazard for rd_addr1=30 stays 1 until reg_write for it drops.
- Queue 3 entries, drain_en=0, assert rst_n low asynchronously -> count=0 and reg_write=0 immediately. After release with drain_en=1 and no new requests, reg_write stays 0 for 10 cycles.
